// File: rtl/gray_pkg.sv
// Shared definitions for the Gray counter slice.
//   bin2gray / gray2bin : width-generic conversions. They work on GRAY_FN_W
//                         bits, so callers zero-extend their operand and
//                         truncate the result with a size cast.
//   tc_cause_t          : why the terminal-count flag fired. It is kept as a
//                         register in the counter so a waveform shows whether
//                         a tc came from a wrap or from a blocked step.
package gray_pkg;

  localparam int GRAY_FN_W = 32;

  typedef logic [1:0] tc_cause_t;

  localparam tc_cause_t TC_NONE = 2'd0;
  localparam tc_cause_t TC_WRAP = 2'd1;
  localparam tc_cause_t TC_SAT  = 2'd2;

  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it, so walk
  // down from the MSB carrying the running XOR.
  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
    logic [GRAY_FN_W-1:0] b;
    b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
    for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_mon.sv
// Single-bit-transition monitor for a registered Gray code.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of the sticky error; also starts an exclusion cycle
//   load     : marks a deliberate jump of the watched code; starts an exclusion cycle
//   gray     : registered Gray value being watched
//   err      : sticky flag, set when two consecutive values differ in more than one bit
module gray_step_mon
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] gray,
  output logic         err
);

  logic [W-1:0] prev_gray_q, prev_gray_d;
  logic         skip_q, skip_d;
  logic         err_q, err_d;

  // skip_q remembers that the current gray value was produced by a clr or
  // load edge, so the jump into it is not a counting step and is not judged.
  always_comb begin
    prev_gray_d = gray;
    skip_d      = clr | load;
    err_d       = err_q;
    if (clr) begin
      err_d = 1'b0;
    end else if (!skip_q && ($countones(gray ^ prev_gray_q) > 1)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray_q <= '0;
      skip_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      skip_q      <= skip_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/gray_counter.sv
// Registered up/down binary counter with an aligned, registered Gray output.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear to zero (highest priority)
//   load     : synchronous load of load_val (beats en)
//   load_val : binary value to load
//   en, up   : count enable and direction (1 = increment)
//   bin      : registered binary count
//   gray     : registered Gray code of bin
//   tc       : terminal-count pulse (wrap when WRAP=1, blocked step when WRAP=0)
//   err      : sticky Gray-transition error from the step monitor
module gray_counter
  import gray_pkg::*;
#(
  parameter int W    = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic         tc,
  output logic         err
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  tc_cause_t    tc_cause_q, tc_cause_d;

  // Gray is encoded from the next binary value rather than from bin_q so
  // both registers update on the same edge and always agree.
  always_comb begin
    bin_d      = bin_q;
    tc_cause_d = TC_NONE;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          if (WRAP) begin
            bin_d      = '0;
            tc_cause_d = TC_WRAP;
          end else begin
            tc_cause_d = TC_SAT;
          end
        end else begin
          bin_d = bin_q + W'(1);
        end
      end else begin
        if (bin_q == '0) begin
          if (WRAP) begin
            bin_d      = MAX_VAL;
            tc_cause_d = TC_WRAP;
          end else begin
            tc_cause_d = TC_SAT;
          end
        end else begin
          bin_d = bin_q - W'(1);
        end
      end
    end
    gray_d = W'(bin2gray(GRAY_FN_W'(bin_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q      <= '0;
      gray_q     <= '0;
      tc_cause_q <= TC_NONE;
    end else begin
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      tc_cause_q <= tc_cause_d;
    end
  end

  gray_step_mon #(
    .W(W)
  ) u_mon (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .gray (gray_q),
    .err  (err)
  );

  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = (tc_cause_q != TC_NONE);

endmodule
